ysyx_23060332_ifu: RTL and testbench

YSYX_23060332_IFU -- requirements
Module: ysyx_23060332_ifu

---
 rtl/ysyx_23060332_ifu.sv | 134 +++++++++++++
 tb/tb_ysyx_23060332_ifu.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060332_ifu.sv
// Instruction fetch unit: issues one read at a time and holds the fetched word until the
// decoder retires it. On retire it advances the PC, or redirects it to the EXU target.
module ysyx_23060332_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] ifu_araddr,
  output logic        ifu_arvalid,
  input  logic        ifu_arready,
  input  logic [31:0] ifu_rdata,
  input  logic        ifu_rvalid,
  output logic        ifu_rready,
  input  logic        jump_en,
  input  logic [31:0] jump_addr,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_addr_q, inst_addr_d;
  logic [31:0] cnt_q, cnt_d;
  logic        arvalid_q, arvalid_d;
  logic        rready_q, rready_d;
  logic        inst_valid_q, inst_valid_d;

  // Next-state, next-PC and captured-instruction logic.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    inst_addr_d = inst_addr_q;
    cnt_d       = cnt_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (arvalid_q && ifu_arready) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (ifu_rvalid) begin
          state_d     = S_HOLD;
          inst_d      = ifu_rdata;
          inst_addr_d = pc_q;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        if (inst_ready) begin
          state_d = S_REQ;
          cnt_d   = cnt_q + 32'd1;
          // Redirect targets are forced halfword-aligned by clearing bit 0.
          if (jump_en) begin
            pc_d = {jump_addr[31:1], 1'b0};
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake outputs are decoded from the next state so they leave flops.
  always_comb begin
    arvalid_d    = 1'b0;
    rready_d     = 1'b0;
    inst_valid_d = 1'b0;
    case (state_d)
      S_REQ:   arvalid_d    = 1'b1;
      S_WAIT:  rready_d     = 1'b1;
      S_HOLD:  inst_valid_d = 1'b1;
      default: begin
        arvalid_d    = 1'b0;
        rready_d     = 1'b0;
        inst_valid_d = 1'b0;
      end
    endcase
  end

  // State, PC, held instruction and retire counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      inst_q       <= 32'd0;
      inst_addr_q  <= 32'd0;
      cnt_q        <= 32'd0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_addr_q  <= inst_addr_d;
      cnt_q        <= cnt_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign ifu_araddr  = pc_q;
  assign ifu_arvalid = arvalid_q;
  assign ifu_rready  = rready_q;
  assign inst_o      = inst_q;
  assign inst_addr   = inst_addr_q;
  assign inst_valid  = inst_valid_q;
  assign inst_cnt    = cnt_q;

endmodule

// File: tb/tb_ysyx_23060332_ifu.sv
// Self-checking bench for the IFU: directed scenarios plus a randomized stall run
// compared against a phase/PC reference model.
module tb_ysyx_23060332_ifu;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic [31:0] ifu_araddr;
  logic        ifu_arvalid;
  logic        ifu_arready;
  logic [31:0] ifu_rdata;
  logic        ifu_rvalid;
  logic        ifu_rready;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic [31:0] inst_o;
  logic [31:0] inst_addr;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_cnt;

  int n_checks;
  int n_pass;

  ysyx_23060332_ifu #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ifu_araddr (ifu_araddr),
    .ifu_arvalid(ifu_arvalid),
    .ifu_arready(ifu_arready),
    .ifu_rdata  (ifu_rdata),
    .ifu_rvalid (ifu_rvalid),
    .ifu_rready (ifu_rready),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .inst_o     (inst_o),
    .inst_addr  (inst_addr),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_cnt   (inst_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    ifu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    ifu_rdata   = 32'd0;
    inst_ready  = 1'b0;
    jump_en     = 1'b0;
    jump_addr   = 32'd0;
  endtask

  // Walks one instruction REQ -> WAIT -> HOLD -> retire with no stalls.
  task automatic fetch_retire(input logic [31:0] rd, input logic je, input logic [31:0] ja);
    ifu_arready = 1'b1;
    tick();
    ifu_arready = 1'b0;
    ifu_rvalid  = 1'b1;
    ifu_rdata   = rd;
    tick();
    ifu_rvalid  = 1'b0;
    inst_ready  = 1'b1;
    jump_en     = je;
    jump_addr   = ja;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    ifu_arready = 1'b1;
    ifu_rvalid  = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (ifu_araddr !== RESET_PC || ifu_arvalid !== 1'b0 || ifu_rready !== 1'b0)
      $display("FAIL reset_bus araddr=%h arvalid=%b rready=%b exp %h/0/0", ifu_araddr, ifu_arvalid, ifu_rready, RESET_PC);
    else n_pass++;
    n_checks++;
    if (inst_valid !== 1'b0 || inst_o !== 32'd0 || inst_addr !== 32'd0 || inst_cnt !== 32'd0)
      $display("FAIL reset_inst valid=%b inst=%h addr=%h cnt=%h exp 0/0/0/0", inst_valid, inst_o, inst_addr, inst_cnt);
    else n_pass++;
    clear_inputs();
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (ifu_arvalid !== 1'b0) $display("FAIL release_idle arvalid=%b exp 0", ifu_arvalid);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (ifu_arvalid !== 1'b1 || ifu_araddr !== RESET_PC)
      $display("FAIL first_req arvalid=%b araddr=%h exp 1/%h", ifu_arvalid, ifu_araddr, RESET_PC);
    else n_pass++;
  endtask

  task automatic test_basic();
    ifu_arready = 1'b1;
    ifu_rvalid  = 1'b1;
    ifu_rdata   = 32'h0010_0093;
    inst_ready  = 1'b1;
    n_checks++;
    if (ifu_araddr !== 32'h8000_0000) $display("FAIL basic_araddr got %h exp 80000000", ifu_araddr);
    else n_pass++;
    tick();
    n_checks++;
    if (ifu_rready !== 1'b1 || ifu_arvalid !== 1'b0)
      $display("FAIL basic_wait rready=%b arvalid=%b exp 1/0", ifu_rready, ifu_arvalid);
    else n_pass++;
    tick();
    n_checks++;
    if (inst_valid !== 1'b1 || inst_o !== 32'h0010_0093 || inst_addr !== 32'h8000_0000)
      $display("FAIL basic_hold valid=%b inst=%h addr=%h exp 1/00100093/80000000", inst_valid, inst_o, inst_addr);
    else n_pass++;
    tick();
    n_checks++;
    if (ifu_araddr !== 32'h8000_0004 || inst_cnt !== 32'd1 || inst_valid !== 1'b0 || ifu_arvalid !== 1'b1)
      $display("FAIL basic_next araddr=%h cnt=%0d valid=%b arvalid=%b exp 80000004/1/0/1", ifu_araddr, inst_cnt, inst_valid, ifu_arvalid);
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_ar_stall();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (ifu_arvalid !== 1'b1 || ifu_araddr !== 32'h8000_0004 || ifu_rready !== 1'b0)
        $display("FAIL ar_stall cyc%0d arvalid=%b araddr=%h rready=%b exp 1/80000004/0", i, ifu_arvalid, ifu_araddr, ifu_rready);
      else n_pass++;
      ifu_rvalid = 1'b1;
      ifu_rdata  = 32'hBAD0_0000;
      tick();
    end
    n_checks++;
    if (ifu_arvalid !== 1'b1 || inst_valid !== 1'b0)
      $display("FAIL ar_stall_end arvalid=%b valid=%b exp 1/0", ifu_arvalid, inst_valid);
    else n_pass++;
    ifu_rvalid  = 1'b0;
    ifu_arready = 1'b1;
    tick();
    n_checks++;
    if (ifu_rready !== 1'b1 || ifu_arvalid !== 1'b0)
      $display("FAIL ar_handshake rready=%b arvalid=%b exp 1/0", ifu_rready, ifu_arvalid);
    else n_pass++;
    ifu_arready = 1'b0;
    ifu_rvalid  = 1'b1;
    ifu_rdata   = 32'h1234_5678;
    tick();
    clear_inputs();
  endtask

  task automatic test_hold_jump();
    for (int i = 0; i < 4; i++) begin
      jump_en   = i[0];
      jump_addr = $urandom;
      n_checks++;
      if (inst_valid !== 1'b1 || inst_o !== 32'h1234_5678 || inst_addr !== 32'h8000_0004 || ifu_arvalid !== 1'b0)
        $display("FAIL hold_stable cyc%0d valid=%b inst=%h addr=%h arvalid=%b exp 1/12345678/80000004/0", i, inst_valid, inst_o, inst_addr, ifu_arvalid);
      else n_pass++;
      tick();
    end
    n_checks++;
    if (inst_o !== 32'h1234_5678 || ifu_araddr !== 32'h8000_0004 || inst_cnt !== 32'd1)
      $display("FAIL hold_jump_ignored inst=%h araddr=%h cnt=%0d exp 12345678/80000004/1", inst_o, ifu_araddr, inst_cnt);
    else n_pass++;
    inst_ready = 1'b1;
    jump_en    = 1'b1;
    jump_addr  = 32'h8000_0103;
    tick();
    n_checks++;
    if (ifu_araddr !== 32'h8000_0102 || inst_cnt !== 32'd2 || inst_valid !== 1'b0)
      $display("FAIL jump_target araddr=%h cnt=%0d valid=%b exp 80000102/2/0", ifu_araddr, inst_cnt, inst_valid);
    else n_pass++;
    clear_inputs();
  endtask

  task automatic test_wrap();
    fetch_retire(32'h0000_0013, 1'b1, 32'hFFFF_FFFD);
    n_checks++;
    if (ifu_araddr !== 32'hFFFF_FFFC) $display("FAIL wrap_setup araddr=%h exp fffffffc", ifu_araddr);
    else n_pass++;
    fetch_retire(32'h0000_0013, 1'b0, 32'h0);
    n_checks++;
    if (ifu_araddr !== 32'h0000_0000 || inst_cnt !== 32'd4)
      $display("FAIL wrap_pc araddr=%h cnt=%0d exp 00000000/4", ifu_araddr, inst_cnt);
    else n_pass++;
  endtask

  task automatic test_reset_in_wait();
    ifu_arready = 1'b1;
    tick();
    ifu_arready = 1'b0;
    n_checks++;
    if (ifu_rready !== 1'b1) $display("FAIL rst_wait_entry rready=%b exp 1", ifu_rready);
    else n_pass++;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (ifu_arvalid !== 1'b0 || ifu_rready !== 1'b0 || ifu_araddr !== RESET_PC || inst_cnt !== 32'd0 || inst_valid !== 1'b0)
      $display("FAIL async_reset arvalid=%b rready=%b araddr=%h cnt=%0d valid=%b exp 0/0/%h/0/0", ifu_arvalid, ifu_rready, ifu_araddr, inst_cnt, inst_valid, RESET_PC);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    ifu_rvalid = 1'b1;
    ifu_rdata  = 32'hDEAD_BEEF;
    n_checks++;
    if (inst_valid !== 1'b0 || ifu_araddr !== RESET_PC || ifu_arvalid !== 1'b1 || ifu_rready !== 1'b0)
      $display("FAIL rst_restart valid=%b araddr=%h arvalid=%b rready=%b exp 0/%h/1/0", inst_valid, ifu_araddr, ifu_arvalid, ifu_rready, RESET_PC);
    else n_pass++;
    tick();
    n_checks++;
    if (inst_valid !== 1'b0 || ifu_rready !== 1'b0 || inst_cnt !== 32'd0 || ifu_araddr !== RESET_PC)
      $display("FAIL rst_late_rvalid valid=%b rready=%b cnt=%0d araddr=%h exp 0/0/0/%h", inst_valid, ifu_rready, inst_cnt, ifu_araddr, RESET_PC);
    else n_pass++;
    clear_inputs();
  endtask

  // Reference model: the fetch protocol as three phases and a PC that moves only on retire.
  task automatic test_random();
    int          phase;
    logic [31:0] mpc;
    logic [31:0] exp_inst;
    int          mcnt;
    int          cycles;
    int          bad;
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    phase    = 0;
    mpc      = RESET_PC;
    mcnt     = 0;
    exp_inst = 32'd0;
    cycles   = 0;
    bad      = 0;
    while (mcnt < 1000 && cycles < 30000) begin
      clear_inputs();
      n_checks++;
      if (inst_cnt !== mcnt[31:0] || ifu_arvalid !== (phase == 0) || ifu_rready !== (phase == 1) || inst_valid !== (phase == 2)) begin
        if (bad < 20) $display("FAIL rand_ctrl cyc%0d cnt=%0d arvalid=%b rready=%b valid=%b exp cnt=%0d phase=%0d", cycles, inst_cnt, ifu_arvalid, ifu_rready, inst_valid, mcnt, phase);
        bad++;
      end else n_pass++;
      ifu_rvalid = ($urandom_range(0, 3) == 0);
      ifu_rdata  = $urandom;
      if (phase == 0) begin
        n_checks++;
        if (ifu_araddr !== mpc) begin
          if (bad < 20) $display("FAIL rand_araddr got %h exp %h", ifu_araddr, mpc);
          bad++;
        end else n_pass++;
        ifu_arready = ($urandom_range(0, 2) != 0);
        if (ifu_arready) phase = 1;
      end else if (phase == 1) begin
        ifu_rvalid = ($urandom_range(0, 2) != 0);
        if (ifu_rvalid) begin
          exp_inst = ifu_rdata;
          phase    = 2;
        end
      end else begin
        n_checks++;
        if (inst_o !== exp_inst || inst_addr !== mpc) begin
          if (bad < 20) $display("FAIL rand_hold inst=%h addr=%h exp %h/%h", inst_o, inst_addr, exp_inst, mpc);
          bad++;
        end else n_pass++;
        inst_ready = ($urandom_range(0, 2) != 0);
        jump_en    = ($urandom_range(0, 3) == 0);
        jump_addr  = $urandom;
        if (inst_ready) begin
          if (jump_en) mpc = jump_addr & 32'hFFFF_FFFE;
          else mpc = mpc + 32'd4;
          mcnt++;
          phase = 0;
        end
      end
      tick();
      cycles++;
    end
    clear_inputs();
    n_checks++;
    if (mcnt != 1000 || inst_cnt !== 32'd1000)
      $display("FAIL rand_total cnt=%0d retires=%0d exp 1000/1000 (cycles=%0d)", inst_cnt, mcnt, cycles);
    else n_pass++;
    n_checks++;
    if (ifu_araddr !== mpc) $display("FAIL rand_final_pc got %h exp %h", ifu_araddr, mpc);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    test_reset();
    test_basic();
    test_ar_stall();
    test_hold_jump();
    test_wrap();
    test_reset_in_wait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
